// File: rtl/boot_sram_arbiter.sv
// Round-robin arbiter between the flash (r0) and UART (r1) boot loaders sharing
// one SRAM write port; holds the CPU in reset until a flash image has landed.
module boot_sram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        r0_valid,
    input  logic [9:0]  r0_addr,
    input  logic [15:0] r0_data,
    input  logic        r0_last,
    output logic        r0_ready,
    input  logic        r1_valid,
    input  logic [9:0]  r1_addr,
    input  logic [15:0] r1_data,
    input  logic        r1_last,
    output logic        r1_ready,
    output logic [9:0]  sram_addr,
    output logic [15:0] sram_data,
    output logic        sram_wen,
    output logic [1:0]  grant,
    output logic        cpu_rst_n,
    output logic        abort
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic {IDLE, BURST} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;   // 0 = r0, 1 = r1
    logic        last_q, last_d;     // last-granted requester
    logic [7:0]  idle_q, idle_d;
    logic        boot_q, boot_d;
    logic [9:0]  addr_d;
    logic [15:0] data_d;
    logic        wen_d, abort_d;
    logic        own_valid, own_last;
    logic [9:0]  own_addr;
    logic [15:0] own_data;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        idle_d    = idle_q;
        boot_d    = boot_q;
        addr_d    = sram_addr;
        data_d    = sram_data;
        wen_d     = 1'b1;
        abort_d   = 1'b0;
        own_valid = owner_q ? r1_valid : r0_valid;
        own_last  = owner_q ? r1_last  : r0_last;
        own_addr  = owner_q ? r1_addr  : r0_addr;
        own_data  = owner_q ? r1_data  : r0_data;
        r0_ready  = (state_q == BURST) && !owner_q;
        r1_ready  = (state_q == BURST) && owner_q;
        grant     = '0;
        if (state_q == BURST) grant = owner_q ? 2'b10 : 2'b01;
        cpu_rst_n = boot_q && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (r0_valid || r1_valid) begin
                    owner_d = (r0_valid && r1_valid) ? ~last_q : r1_valid;
                    last_d  = owner_d;
                    idle_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                // A beat offered while the counter sits at TIMEOUT is still taken:
                // ready is already high, so dropping it would lose data.
                if (own_valid) begin
                    wen_d  = 1'b0;
                    addr_d = own_addr;
                    data_d = own_data;
                    idle_d = '0;
                    if (own_last) begin
                        state_d = IDLE;
                        if (!owner_q) boot_d = 1'b1;
                    end
                end else if (idle_q == TIMEOUT_CNT) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            idle_q    <= '0;
            boot_q    <= 1'b0;
            sram_addr <= '0;
            sram_data <= '0;
            sram_wen  <= 1'b1;
            abort     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            idle_q    <= idle_d;
            boot_q    <= boot_d;
            sram_addr <= addr_d;
            sram_data <= data_d;
            sram_wen  <= wen_d;
            abort     <= abort_d;
        end
    end

endmodule

// File: tb/tb_boot_sram_arbiter.sv
// Self-checking bench for boot_sram_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_boot_sram_arbiter;

    localparam int unsigned TO = 4;

    logic        i_clk, i_rst_n;
    logic        r0_valid, r0_last, r0_ready;
    logic [9:0]  r0_addr;
    logic [15:0] r0_data;
    logic        r1_valid, r1_last, r1_ready;
    logic [9:0]  r1_addr;
    logic [15:0] r1_data;
    logic [9:0]  sram_addr;
    logic [15:0] sram_data;
    logic        sram_wen, cpu_rst_n, abort;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    // Reference model: owner -1 means no burst in progress
    int          m_owner, m_prev, m_quiet;
    bit          m_boot, m_wr, m_abort;
    logic [9:0]  m_addr;
    logic [15:0] m_data;

    boot_sram_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_last(r0_last), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_last(r1_last), .r1_ready(r1_ready),
        .sram_addr(sram_addr), .sram_data(sram_data), .sram_wen(sram_wen),
        .grant(grant), .cpu_rst_n(cpu_rst_n), .abort(abort)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic model_step();
        bit ov, ol;
        if (!i_rst_n) begin
            m_owner = -1; m_prev = 1; m_quiet = 0; m_boot = 0;
            m_wr = 0; m_abort = 0; m_addr = '0; m_data = '0;
        end else begin
            m_wr = 0;
            m_abort = 0;
            if (m_owner < 0) begin
                if (r0_valid && r1_valid) m_owner = 1 - m_prev;
                else if (r0_valid) m_owner = 0;
                else if (r1_valid) m_owner = 1;
                if (m_owner >= 0) begin
                    m_prev = m_owner;
                    m_quiet = 0;
                end
            end else begin
                ov = (m_owner == 0) ? r0_valid : r1_valid;
                ol = (m_owner == 0) ? r0_last : r1_last;
                if (ov) begin
                    m_wr = 1;
                    m_addr = (m_owner == 0) ? r0_addr : r1_addr;
                    m_data = (m_owner == 0) ? r0_data : r1_data;
                    m_quiet = 0;
                    if (ol) begin
                        if (m_owner == 0) m_boot = 1;
                        m_owner = -1;
                    end
                end else if (m_quiet == int'(TO)) begin
                    m_owner = -1;
                    m_abort = 1;
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                end
            end
        end
    endtask

    // Drives one cycle of inputs, advances model and DUT, returns 1 ns after the edge
    task automatic cyc(input logic rn,
                       input logic v0, input logic [9:0] a0, input logic [15:0] d0, input logic l0,
                       input logic v1, input logic [9:0] a1, input logic [15:0] d1, input logic l1);
        i_rst_n = rn;
        r0_valid = v0; r0_addr = a0; r0_data = d0; r0_last = l0;
        r1_valid = v1; r1_addr = a1; r1_data = d1; r1_last = l1;
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 1, 10'h3FF, 16'hFFFF, 0, 1, 10'h155, 16'h5555, 0);
        checks++; if (sram_wen !== 1'b1) begin errors++; $display("FAIL reset_wen got=%b exp=1", sram_wen); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", r0_ready, r1_ready); end
        checks++; if (sram_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
        checks++; if (sram_data !== 16'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", sram_data); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu got=%b exp=0", cpu_rst_n); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", abort); end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_idle_grant got=%b exp=00", grant); end
    endtask

    task automatic test_r0_burst();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 10'd0, 16'hA000, 0, 0, 0, 0, 0);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL burst_grant got=%b exp=01", grant); end
        checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL burst_ready got=%b exp=1", r0_ready); end
        checks++; if (sram_wen !== 1'b1) begin errors++; $display("FAIL burst_nowrite_at_grant got=%b exp=1", sram_wen); end
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 10'(k), 16'hA000 + 16'(k), k == 3, 0, 0, 0, 0);
            checks++; if (sram_wen !== 1'b0) begin errors++; $display("FAIL burst_wen beat=%0d got=%b exp=0", k, sram_wen); end
            checks++; if (sram_addr !== 10'(k)) begin errors++; $display("FAIL burst_addr beat=%0d got=%h exp=%h", k, sram_addr, k); end
            checks++; if (sram_data !== 16'hA000 + 16'(k)) begin errors++; $display("FAIL burst_data beat=%0d got=%h exp=%h", k, sram_data, 16'hA000 + 16'(k)); end
            checks++; if (cpu_rst_n !== (k == 3)) begin errors++; $display("FAIL burst_cpu beat=%0d got=%b exp=%b", k, cpu_rst_n, k == 3); end
        end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_end_grant got=%b exp=00", grant); end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (sram_wen !== 1'b1) begin errors++; $display("FAIL burst_after_wen got=%b exp=1", sram_wen); end
        checks++; if ({sram_addr, sram_data} !== {10'd3, 16'hA003}) begin errors++; $display("FAIL burst_hold got=%h/%h exp=3/a003", sram_addr, sram_data); end
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL burst_cpu_release got=%b exp=1", cpu_rst_n); end
    endtask

    task automatic test_round_robin();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 10'd10, 16'h1111, 1, 1, 10'd20, 16'h2222, 1);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_first got=%b exp=01", grant); end
        cyc(1, 1, 10'd10, 16'h1111, 1, 1, 10'd20, 16'h2222, 1);
        checks++; if ({sram_wen, sram_addr, sram_data} !== {1'b0, 10'd10, 16'h1111}) begin errors++; $display("FAIL rr_r0_write got=%b/%h/%h exp=0/00a/1111", sram_wen, sram_addr, sram_data); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_gap got=%b exp=00", grant); end
        cyc(1, 1, 10'd10, 16'h1111, 1, 1, 10'd20, 16'h2222, 1);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rr_second got=%b exp=10", grant); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL rr_cpu_busy got=%b exp=0", cpu_rst_n); end
        cyc(1, 0, 0, 0, 0, 1, 10'd20, 16'h2222, 1);
        checks++; if ({sram_wen, sram_addr, sram_data} !== {1'b0, 10'd20, 16'h2222}) begin errors++; $display("FAIL rr_r1_write got=%b/%h/%h exp=0/014/2222", sram_wen, sram_addr, sram_data); end
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL rr_cpu_done got=%b exp=1", cpu_rst_n); end
    endtask

    task automatic test_non_owner();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 10'd30, 16'h3000, 0, 1, 10'd40, 16'h4000, 1);
        checks++; if ({grant, r1_ready} !== 3'b010) begin errors++; $display("FAIL no_grant got=%b/%b exp=01/0", grant, r1_ready); end
        cyc(1, 1, 10'd30, 16'h3000, 0, 1, 10'd40, 16'h4000, 1);
        checks++; if ({sram_wen, sram_addr, r1_ready} !== {1'b0, 10'd30, 1'b0}) begin errors++; $display("FAIL no_beat0 got=%b/%h/%b exp=0/01e/0", sram_wen, sram_addr, r1_ready); end
        cyc(1, 1, 10'd31, 16'h3001, 1, 1, 10'd40, 16'h4000, 1);
        checks++; if ({sram_wen, sram_addr, grant} !== {1'b0, 10'd31, 2'b00}) begin errors++; $display("FAIL no_beat1 got=%b/%h/%b exp=0/01f/00", sram_wen, sram_addr, grant); end
        cyc(1, 0, 0, 0, 0, 1, 10'd40, 16'h4000, 1);
        checks++; if ({grant, sram_wen, sram_addr} !== {2'b10, 1'b1, 10'd31}) begin errors++; $display("FAIL no_r1_grant got=%b/%b/%h exp=10/1/01f", grant, sram_wen, sram_addr); end
        cyc(1, 0, 0, 0, 0, 1, 10'd40, 16'h4000, 1);
        checks++; if ({sram_wen, sram_addr, sram_data} !== {1'b0, 10'd40, 16'h4000}) begin errors++; $display("FAIL no_r1_write got=%b/%h/%h exp=0/028/4000", sram_wen, sram_addr, sram_data); end
    endtask

    task automatic test_timeout();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 10'd5, 16'h5005, 0, 0, 0, 0, 0);
        cyc(1, 1, 10'd5, 16'h5005, 0, 0, 0, 0, 0);
        checks++; if ({sram_wen, sram_addr} !== {1'b0, 10'd5}) begin errors++; $display("FAIL to_write got=%b/%h exp=0/005", sram_wen, sram_addr); end
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++; if ({grant, abort, sram_wen} !== 4'b0101) begin errors++; $display("FAIL to_wait%0d got=%b/%b/%b exp=01/0/1", k, grant, abort, sram_wen); end
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({grant, abort, sram_wen} !== 4'b0011) begin errors++; $display("FAIL to_abort got=%b/%b/%b exp=00/1/1", grant, abort, sram_wen); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL to_boot_unchanged got=%b exp=0", cpu_rst_n); end
        cyc(1, 1, 10'd6, 16'h6006, 1, 1, 10'd9, 16'h9009, 1);
        checks++; if ({grant, abort} !== 3'b100) begin errors++; $display("FAIL to_next_rr got=%b/%b exp=10/0", grant, abort); end
        cyc(1, 1, 10'd6, 16'h6006, 1, 1, 10'd9, 16'h9009, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL to_cpu_after_r1 got=%b exp=0", cpu_rst_n); end
    endtask

    task automatic test_reset_midburst();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 10'd7, 16'h7007, 0, 0, 0, 0, 0);
        cyc(1, 1, 10'd7, 16'h7007, 0, 0, 0, 0, 0);
        checks++; if ({sram_wen, sram_addr} !== {1'b0, 10'd7}) begin errors++; $display("FAIL rm_write got=%b/%h exp=0/007", sram_wen, sram_addr); end
        cyc(0, 1, 10'd8, 16'h7008, 0, 0, 0, 0, 0);
        checks++; if (sram_wen !== 1'b1) begin errors++; $display("FAIL rm_drop got=%b exp=1", sram_wen); end
        checks++; if ({sram_addr, sram_data} !== 26'd0) begin errors++; $display("FAIL rm_addrdata got=%h/%h exp=0/0", sram_addr, sram_data); end
        checks++; if ({grant, r0_ready, r1_ready, cpu_rst_n, abort} !== 6'd0) begin errors++; $display("FAIL rm_ctrl got=%b/%b%b/%b/%b exp=0", grant, r0_ready, r1_ready, cpu_rst_n, abort); end
        cyc(1, 1, 10'd8, 16'h7008, 0, 1, 10'd1, 16'h1, 0);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_lastgrant got=%b exp=01", grant); end
    endtask

    task automatic test_r1_only();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 10'd100, 16'hB000, 0);
        checks++; if ({grant, r1_ready, r0_ready} !== 4'b1010) begin errors++; $display("FAIL r1_grant got=%b/%b%b exp=10/10", grant, r1_ready, r0_ready); end
        cyc(1, 0, 0, 0, 0, 1, 10'd100, 16'hB000, 0);
        cyc(1, 0, 0, 0, 0, 1, 10'd101, 16'hB001, 1);
        checks++; if ({sram_wen, sram_addr, sram_data} !== {1'b0, 10'd101, 16'hB001}) begin errors++; $display("FAIL r1_write got=%b/%h/%h exp=0/065/b001", sram_wen, sram_addr, sram_data); end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({grant, cpu_rst_n} !== 3'b000) begin errors++; $display("FAIL r1_cpu got=%b/%b exp=00/0", grant, cpu_rst_n); end
    endtask

    task automatic test_random();
        logic [1:0] eg;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 79) != 0,
                $urandom_range(0, 99) < 55, 10'($urandom), 16'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 99) < 45, 10'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
            eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
            checks++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", n, grant, eg); end
            checks++; if ({r1_ready, r0_ready} !== eg) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b", n, r1_ready, r0_ready, eg); end
            checks++; if (sram_wen !== !m_wr) begin errors++; $display("FAIL rnd_wen cyc=%0d got=%b exp=%b", n, sram_wen, !m_wr); end
            checks++; if (sram_addr !== m_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", n, sram_addr, m_addr); end
            checks++; if (sram_data !== m_data) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, sram_data, m_data); end
            checks++; if (abort !== m_abort) begin errors++; $display("FAIL rnd_abort cyc=%0d got=%b exp=%b", n, abort, m_abort); end
            checks++; if (cpu_rst_n !== (m_boot && m_owner < 0)) begin errors++; $display("FAIL rnd_cpu cyc=%0d got=%b exp=%b", n, cpu_rst_n, m_boot && m_owner < 0); end
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        r0_valid = 1'b0; r0_addr = '0; r0_data = '0; r0_last = 1'b0;
        r1_valid = 1'b0; r1_addr = '0; r1_data = '0; r1_last = 1'b0;
        test_reset();
        test_r0_burst();
        test_round_robin();
        test_non_owner();
        test_timeout();
        test_reset_midburst();
        test_r1_only();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
